// File: rtl/llr_frame_buffer.sv
// Ping-pong serial-to-parallel LLR buffer: Q-bit LLRs in, P-wide sets out; set_valid rises the cycle after the P-th accept.
// Backpressure: in_ready drops only when both banks hold unconsumed sets and returns the cycle after a consume.
module llr_frame_buffer #(
    parameter int Q = 6,
    parameter int P = 32,
    parameter int N = 1024,
    localparam int SETS = N / P,
    localparam int CW = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int PW = $clog2(P)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [Q-1:0]    in_llr,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [P*Q-1:0]  set_llr,
    output logic            set_valid,
    input  logic            set_ready,
    output logic [CW-1:0]   set_index,
    output logic            set_last,
    output logic [7:0]      frame_count
);

    logic [1:0][P*Q-1:0] bank;
    logic [1:0]          full;
    logic                wsel;
    logic                rsel;
    logic [PW-1:0]       wcnt;
    logic [CW-1:0]       ridx;

    logic accept;
    logic consume;
    logic wr_done;
    logic ridx_last;

    assign in_ready  = !full[wsel];
    assign accept    = in_valid && in_ready;
    assign set_valid = full[rsel];
    assign consume   = set_valid && set_ready;
    assign wr_done   = (wcnt == PW'(P - 1));
    assign ridx_last = (ridx == CW'(SETS - 1));

    assign set_llr   = bank[rsel];
    assign set_index = ridx;
    assign set_last  = set_valid && ridx_last;

    // Completion and consume never collide: completion needs F[wsel]=0, consume needs F[rsel]=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank        <= '0;
            full        <= '0;
            wsel        <= 1'b0;
            rsel        <= 1'b0;
            wcnt        <= '0;
            ridx        <= '0;
            frame_count <= '0;
        end else if (flush) begin
            full <= '0;
            wsel <= 1'b0;
            rsel <= 1'b0;
            wcnt <= '0;
            ridx <= '0;
        end else begin
            if (accept) begin
                bank[wsel][wcnt*Q +: Q] <= in_llr;
                if (wr_done) begin
                    full[wsel] <= 1'b1;
                    wcnt       <= '0;
                    wsel       <= ~wsel;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (consume) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
                ridx       <= ridx_last ? '0 : ridx + 1'b1;
                if (ridx_last) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_llr_frame_buffer.sv
// Bench for llr_frame_buffer: small instance (P=4, N=16) for vectors, corner sequences and random model check,
// plus a default-parameter instance (P=32, N=1024) for the basic set.
module tb_llr_frame_buffer;
    localparam int Q    = 6;
    localparam int P    = 4;
    localparam int N    = 16;
    localparam int SETS = N / P;
    localparam int PB   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flush, in_valid, set_ready, in_ready, set_valid, set_last;
    logic [Q-1:0]   in_llr;
    logic [P*Q-1:0] set_llr;
    logic [1:0]     set_index;
    logic [7:0]     frame_count;

    logic            b_in_valid, b_set_ready, b_in_ready, b_set_valid, b_set_last;
    logic [Q-1:0]    b_in_llr;
    logic [PB*Q-1:0] b_set_llr;
    logic [4:0]      b_set_index;
    logic [7:0]      b_frame_count;

    llr_frame_buffer #(.Q(Q), .P(P), .N(N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_llr(in_llr), .in_valid(in_valid),
        .in_ready(in_ready), .set_llr(set_llr), .set_valid(set_valid), .set_ready(set_ready),
        .set_index(set_index), .set_last(set_last), .frame_count(frame_count)
    );

    llr_frame_buffer dut_big (
        .clk(clk), .rst(rst), .flush(flush), .in_llr(b_in_llr), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .set_llr(b_set_llr), .set_valid(b_set_valid), .set_ready(b_set_ready),
        .set_index(b_set_index), .set_last(b_set_last), .frame_count(b_frame_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [Q-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_llr    = d;
        set_ready = r;
        flush     = f;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Set whose first LLR (slot 0, LSBs) is a, followed by a+1, a+2, a+3.
    function automatic logic [23:0] pk(input int a);
        pk = {6'(a + 3), 6'(a + 2), 6'(a + 1), 6'(a)};
    endfunction

    typedef struct {
        logic        v;
        logic [5:0]  d;
        logic        r;
        logic        e_rdy;
        logic        e_sv;
        logic [1:0]  e_idx;
        logic        e_last;
        logic [23:0] e_set;
        logic [7:0]  e_fc;
    } vec_t;

    function automatic vec_t mk(input int v, input int d, input int r, input int e_rdy, input int e_sv,
                                input int e_idx, input int e_last, input logic [23:0] e_set, input int e_fc);
        vec_t t;
        t.v = v[0]; t.d = d[5:0]; t.r = r[0]; t.e_rdy = e_rdy[0]; t.e_sv = e_sv[0];
        t.e_idx = e_idx[1:0]; t.e_last = e_last[0]; t.e_set = e_set; t.e_fc = e_fc[7:0];
        return t;
    endfunction

    vec_t tbl [23];

    // Reference model state: completed sets awaiting consume, and the partial set being gathered.
    logic [23:0] m_pend [$];
    logic [5:0]  m_part [$];
    int          m_idx;
    int          m_fc;

    initial begin
        int nsets;
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        b_in_valid = 1'b0; b_in_llr = '0; b_set_ready = 1'b0;
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset set_valid", 64'(set_valid), 64'd0);
        chk("reset set_llr", 64'(set_llr), 64'd0);
        chk("reset set_index", 64'(set_index), 64'd0);
        chk("reset set_last", 64'(set_last), 64'd0);
        chk("reset frame_count", 64'(frame_count), 64'd0);
        chk("reset big set_valid", 64'(b_set_valid), 64'd0);
        tick();
        tick();
        rst = 1'b1;

        // Basic set on the P=32 instance.
        for (int k = 0; k < PB; k++) begin
            b_in_valid = 1'b1;
            b_in_llr   = 6'(k);
            chk($sformatf("basic in_ready %0d", k), 64'(b_in_ready), 64'd1);
            chk($sformatf("basic early valid %0d", k), 64'(b_set_valid), 64'd0);
            tick();
        end
        b_in_valid = 1'b0;
        chk("basic set_valid", 64'(b_set_valid), 64'd1);
        chk("basic set_index", 64'(b_set_index), 64'd0);
        chk("basic set_last", 64'(b_set_last), 64'd0);
        chk("basic in_ready after", 64'(b_in_ready), 64'd1);
        for (int k = 0; k < PB; k++)
            chk($sformatf("basic slot %0d", k), 64'(b_set_llr[k*Q +: Q]), 64'(k));

        // Backpressure, then completion coinciding with a consume, then frame end.
        tbl[0]  = mk(1,  1, 0, 1, 0, 0, 0, 24'd0, 0);
        tbl[1]  = mk(1,  2, 0, 1, 0, 0, 0, 24'd0, 0);
        tbl[2]  = mk(1,  3, 0, 1, 0, 0, 0, 24'd0, 0);
        tbl[3]  = mk(1,  4, 0, 1, 0, 0, 0, 24'd0, 0);
        tbl[4]  = mk(1,  5, 0, 1, 1, 0, 0, pk(1), 0);
        tbl[5]  = mk(1,  6, 0, 1, 1, 0, 0, pk(1), 0);
        tbl[6]  = mk(1,  7, 0, 1, 1, 0, 0, pk(1), 0);
        tbl[7]  = mk(1,  8, 0, 1, 1, 0, 0, pk(1), 0);
        tbl[8]  = mk(1,  9, 0, 0, 1, 0, 0, pk(1), 0);
        tbl[9]  = mk(1,  9, 1, 0, 1, 0, 0, pk(1), 0);
        tbl[10] = mk(1,  9, 0, 1, 1, 1, 0, pk(5), 0);
        tbl[11] = mk(1, 10, 0, 1, 1, 1, 0, pk(5), 0);
        tbl[12] = mk(1, 11, 0, 1, 1, 1, 0, pk(5), 0);
        tbl[13] = mk(1, 12, 0, 1, 1, 1, 0, pk(5), 0);
        tbl[14] = mk(0,  0, 1, 0, 1, 1, 0, pk(5), 0);
        tbl[15] = mk(0,  0, 0, 1, 1, 2, 0, pk(9), 0);
        tbl[16] = mk(1, 13, 0, 1, 1, 2, 0, pk(9), 0);
        tbl[17] = mk(1, 14, 0, 1, 1, 2, 0, pk(9), 0);
        tbl[18] = mk(1, 15, 0, 1, 1, 2, 0, pk(9), 0);
        tbl[19] = mk(1, 16, 1, 1, 1, 2, 0, pk(9), 0);
        tbl[20] = mk(0,  0, 0, 1, 1, 3, 1, pk(13), 0);
        tbl[21] = mk(0,  0, 1, 1, 1, 3, 1, pk(13), 0);
        tbl[22] = mk(0,  0, 0, 1, 0, 0, 0, 24'd0, 1);

        do_reset();
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d set_valid", i), 64'(set_valid), 64'(tbl[i].e_sv));
            chk($sformatf("vec%0d set_index", i), 64'(set_index), 64'(tbl[i].e_idx));
            chk($sformatf("vec%0d set_last", i), 64'(set_last), 64'(tbl[i].e_last));
            chk($sformatf("vec%0d frame_count", i), 64'(frame_count), 64'(tbl[i].e_fc));
            if (tbl[i].e_sv)
                chk($sformatf("vec%0d set_llr", i), 64'(set_llr), 64'(tbl[i].e_set));
            tick();
        end

        // Frame wrap: 40 LLRs with set_ready held high.
        do_reset();
        nsets = 0;
        for (int c = 0; c < 46; c++) begin
            drive(c < 40, 6'(c), 1'b1, 1'b0);
            if (set_valid) begin
                chk($sformatf("wrap set%0d index", nsets), 64'(set_index), 64'(nsets % SETS));
                chk($sformatf("wrap set%0d last", nsets), 64'(set_last), 64'((nsets % SETS) == SETS - 1));
                chk($sformatf("wrap set%0d data", nsets), 64'(set_llr), 64'(pk(4 * nsets)));
                nsets++;
            end
            tick();
        end
        chk("wrap set count", 64'(nsets), 64'd10);
        chk("wrap frame_count", 64'(frame_count), 64'd2);

        // Flush mid-frame with a pending set at index 2 and a partial set.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 6'(50 + c), 1'b0, 1'b0);
            tick();
        end
        chk("preflush set_index", 64'(set_index), 64'd2);
        drive(1'b1, 6'd56, 1'b0, 1'b1);
        tick();
        chk("flush set_valid", 64'(set_valid), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd1);
        chk("flush set_index", 64'(set_index), 64'd0);
        chk("flush frame_count kept", 64'(frame_count), 64'd2);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 6'(20 + c), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("postflush set_valid", 64'(set_valid), 64'd1);
        chk("postflush set_index", 64'(set_index), 64'd0);
        chk("postflush set_llr", 64'(set_llr), 64'(pk(20)));

        // Asynchronous reset between edges with a set pending.
        #2;
        rst = 1'b0;
        #1;
        chk("async set_valid", 64'(set_valid), 64'd0);
        chk("async set_llr", 64'(set_llr), 64'd0);
        chk("async frame_count", 64'(frame_count), 64'd0);
        chk("async in_ready", 64'(in_ready), 64'd1);
        chk("async set_index", 64'(set_index), 64'd0);
        tick();
        rst = 1'b1;

        // Random traffic against the queue model.
        do_reset();
        m_pend.delete(); m_part.delete(); m_idx = 0; m_fc = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        v, r, f, acc, con;
            logic [5:0]  d;
            logic [23:0] s;
            logic        e_sv;
            v = ($urandom_range(0, 3) != 0);
            r = ((i / 300) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            f = ($urandom_range(0, 149) == 0);
            d = 6'($urandom);
            drive(v, d, r, f);
            e_sv = (m_pend.size() > 0);
            chk($sformatf("rand cyc%0d {rdy,sv,idx,last,fc,set}", i),
                {27'd0, in_ready, set_valid, set_index, set_last, frame_count, e_sv ? set_llr : 24'd0},
                {27'd0, 1'(m_pend.size() < 2), e_sv, 2'(m_idx), 1'(e_sv && m_idx == SETS - 1),
                 8'(m_fc), e_sv ? m_pend[0] : 24'd0});
            tick();
            acc = v && (m_pend.size() < 2);
            con = r && (m_pend.size() > 0);
            if (f) begin
                m_pend.delete();
                m_part.delete();
                m_idx = 0;
            end else begin
                if (con) begin
                    void'(m_pend.pop_front());
                    if (m_idx == SETS - 1) m_fc = (m_fc + 1) % 256;
                    m_idx = (m_idx + 1) % SETS;
                end
                if (acc) begin
                    m_part.push_back(d);
                    if (m_part.size() == P) begin
                        for (int k = 0; k < P; k++) s[k*Q +: Q] = m_part[k];
                        m_pend.push_back(s);
                        m_part.delete();
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/llr_frame_buffer.md
Name: llr_frame_buffer

Overview:
- Parametrised successor to the channel LLR serial-to-parallel buffer in the SCAN polar decoder front end.
- Collects serial Q-bit channel LLRs into P-wide sets and hands each set to the decoder core with a valid/ready handshake.
- Ping-pong banks let input streaming continue while the decoder holds the previous set.
- Tracks set index within an N-bit frame and flags the last set of each frame.

Parameters:
- Q, 6, LLR width in bits.
- P, 32, LLRs per output set. Must be a power of 2 and at least 2.
- N, 1024, frame length in LLRs. Must be a multiple of P.
- Derived localparams: SETS = N/P; CW = max(1, clog2(SETS)); PW = clog2(P).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous frame abort, active-high
- in_llr  in  Q  serial channel LLR
- in_valid  in  1  in_llr valid this cycle
- in_ready  out  1  buffer can accept in_llr
- set_llr  out  P*Q  parallel LLR set
- set_valid  out  1  set_llr holds a complete set
- set_ready  in  1  decoder consumes set this cycle
- set_index  out  CW  index of the presented set within the frame, 0..SETS-1
- set_last  out  1  presented set is the last of the frame
- frame_count  out  8  completed frames consumed, wraps at 256

Behaviour:
- Storage: two banks B0 and B1, each P*Q bits, plus full flags F0 and F1.
- Pointers:
  - wsel selects the write bank; wcnt (PW bits) is the slot within it.
  - rsel selects the read bank; ridx (CW bits) is the set index.
- Input accept: occurs when in_valid && in_ready. in_ready = !F[wsel], combinational from registered state.
- On accept:
  - Write in_llr to slot wcnt, bits [(wcnt+1)*Q-1 : wcnt*Q]. The first LLR of a set lands in slot 0, the LSBs.
  - If wcnt == P-1: set F[wsel] = 1, wcnt = 0, toggle wsel. Otherwise wcnt += 1.
- Output presentation:
  - set_valid = F[rsel]; set_llr = bank[rsel].
  - set_index = ridx; set_last = set_valid && (ridx == SETS-1).
- Output consume: occurs when set_valid && set_ready.
  - Clear F[rsel] and toggle rsel.
  - ridx = (ridx == SETS-1) ? 0 : ridx+1.
  - If set_last, frame_count += 1 (mod 256).
- Latency:
  - The P-th LLR accepted at edge t gives set_valid = 1 from edge t onward, i.e. the cycle after acceptance.
  - set_llr is stable while set_valid = 1 and set_ready = 0.
- Throughput: 1 LLR per cycle is sustained indefinitely if set_ready is asserted at least once per P cycles.
- Backpressure:
  - When both banks are full, in_ready = 0 and in_llr is ignored.
  - in_ready rises the cycle after a consume.
- Simultaneous completion and consume in the same cycle: both happen, since they touch different banks.
  - Example: completion sets F1 while consume clears F0, with no lost or duplicated set.
- set_ready while set_valid = 0: ignored, no state change.
- flush:
  - Next edge clears wcnt, wsel, rsel, ridx, F0 and F1.
  - Bank contents and frame_count are kept.
  - flush overrides any same-cycle accept or consume.
- Reset (rst = 0, asynchronous):
  - Clears all registers, banks, flags and frame_count.
  - Outputs under reset: set_llr = 0, set_valid = 0, set_index = 0, set_last = 0, frame_count = 0, in_ready = 1.
  - Reset asserted mid-set discards partial data. Deassertion is synchronised externally.
- Arithmetic: no LLR modification. Data passes bit-exact, sign and magnitude untouched.

Test Plan:
- Basic set (P=32, N=1024): after reset, stream LLRs 0..31, one per cycle, set_ready = 0.
  -> set_valid rises the cycle after LLR 31.
  -> set_llr slot k = k.
  -> set_index = 0, set_last = 0, in_ready stays 1.
- Backpressure (P=4, N=16, set_ready = 0): stream 12 LLRs continuously.
  -> in_ready falls after the 8th accept.
  -> LLRs 9..12 are held off.
  -> Pulse set_ready: first set = 1,2,3,4; in_ready returns next cycle; later sets = 5..8, then 9..12.
- Frame wrap (P=4, N=16): stream 40 LLRs with set_ready = 1.
  -> set_index sequence 0,1,2,3,0,1,2,3,0,1.
  -> set_last on sets 3 and 7.
  -> frame_count = 2 at end.
- Simultaneous events (P=4): assert set_ready on the same cycle the 4th LLR of the second bank is accepted.
  -> first set consumed, second set presented next cycle with set_index = 1, no data loss.
- flush mid-frame (P=4): accept 6 LLRs, assert flush with in_valid = 1.
  -> next cycle set_valid = 0, in_ready = 1, set_index = 0.
  -> the following 4 LLRs form a set whose index is 0.
- Async reset: drop rst between clock edges while one set is pending.
  -> set_valid = 0, set_llr = 0, frame_count = 0 immediately, without waiting for an edge.
